// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM encoding and sizing constants for the parity frame checker
package parity_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_BITS = 8;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/xor_gate.sv
// rtl/xor_gate.sv - two-input xor used for the running-parity update
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial LSB-first frame assembler with parity check and error count
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int               CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] data_q;
    logic                 running_parity;
    logic                 parity_next;
    logic                 frame_err;
    logic                 accept;
    logic                 handshake;

    xor_gate u_parity_xor (
        .a (running_parity),
        .b (bit_in),
        .y (parity_next)
    );

    assign accept    = bit_valid & bit_ready;
    assign handshake = out_valid & out_ready;
    assign frame_err = parity_next ^ PARITY_ODD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bit_ready  = 1'b0;
        case (state)
            COLLECT: begin
                bit_ready = 1'b1;
                if (bit_valid && bit_cnt == LAST_IDX) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                bit_ready = 1'b1;
                if (bit_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // data_q collects the frame in flight; data_out only moves when a frame completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt        <= '0;
            data_q         <= '0;
            running_parity <= 1'b0;
            data_out       <= '0;
            out_valid      <= 1'b0;
            parity_err     <= 1'b0;
            err_count      <= '0;
        end else begin
            if (state == COLLECT && accept) begin
                data_q[bit_cnt] <= bit_in;
                running_parity  <= parity_next;
                bit_cnt         <= (bit_cnt == LAST_IDX) ? '0 : bit_cnt + CNT_W'(1);
            end
            if (state == PARITY && accept) begin
                data_out   <= data_q;
                parity_err <= frame_err;
                out_valid  <= 1'b1;
                if (frame_err && err_count != ERR_CNT_MAX) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
            if (handshake) begin
                out_valid      <= 1'b0;
                running_parity <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - self-checking bench for parity_frame_checker (even and odd instances)
module tb_parity_frame_checker;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          out_ready = 1'b0;

    logic          bit_ready_e, out_valid_e, parity_err_e;
    logic [DB-1:0] data_out_e;
    logic [7:0]    err_count_e;
    logic          bit_ready_o, out_valid_o, parity_err_o;
    logic [DB-1:0] data_out_o;
    logic [7:0]    err_count_o;

    int checks = 0;
    int errors = 0;
    int gap_tbl[DB];

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_BITS(DB), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_e), .data_out(data_out_e), .out_valid(out_valid_e),
        .out_ready(out_ready), .parity_err(parity_err_e), .err_count(err_count_e)
    );

    parity_frame_checker #(.DATA_BITS(DB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_o), .data_out(data_out_o), .out_valid(out_valid_o),
        .out_ready(out_ready), .parity_err(parity_err_o), .err_count(err_count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a list of accepted bits; a frame is complete once DB+1 bits are in
    logic [DB-1:0] m_bits;
    int            m_n;
    bit            m_valid;
    logic [DB-1:0] m_data;
    bit            m_perr_e, m_perr_o;
    int            m_ec_e, m_ec_o;

    always @(posedge clk or posedge rst) begin
        int ones;
        if (rst) begin
            m_n = 0; m_valid = 0; m_data = '0; m_bits = '0;
            m_perr_e = 0; m_perr_o = 0; m_ec_e = 0; m_ec_o = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                m_n = 0;
            end
        end else if (bit_valid) begin
            if (m_n < DB) begin
                m_bits[m_n] = bit_in;
                m_n++;
            end else begin
                ones     = $countones(m_bits) + int'(bit_in);
                m_data   = m_bits;
                m_perr_e = (ones % 2) == 1;
                m_perr_o = (ones % 2) == 0;
                m_valid  = 1;
                if (m_perr_e && m_ec_e < 255) m_ec_e++;
                if (m_perr_o && m_ec_o < 255) m_ec_o++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_bit_ready_e", 32'(bit_ready_e), 32'(!m_valid));
            chk("m_bit_ready_o", 32'(bit_ready_o), 32'(!m_valid));
            chk("m_out_valid_e", 32'(out_valid_e), 32'(m_valid));
            chk("m_out_valid_o", 32'(out_valid_o), 32'(m_valid));
            chk("m_data_out_e", 32'(data_out_e), 32'(m_data));
            chk("m_data_out_o", 32'(data_out_o), 32'(m_data));
            chk("m_parity_err_e", 32'(parity_err_e), 32'(m_perr_e));
            chk("m_parity_err_o", 32'(parity_err_o), 32'(m_perr_o));
            chk("m_err_count_e", 32'(err_count_e), 32'(m_ec_e));
            chk("m_err_count_o", 32'(err_count_o), 32'(m_ec_o));
        end
    end

    task automatic send_bit(input logic b, input int gap);
        logic r;
        int   n;
        bit_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bit_valid = 1'b1;
        bit_in    = b;
        n = 0;
        do begin
            @(negedge clk);
            r = bit_ready_e;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 20);
        if (!r) begin
            checks++; errors++;
            $display("FAIL accept_timeout: bit_ready stayed 0 for %0d cycles", n);
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p);
        for (int i = 0; i < DB; i++) send_bit(d[i], gap_tbl[i]);
        send_bit(p, 0);
    endtask

    task automatic drain();
        logic v;
        int   n;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            v = out_valid_e;
            @(posedge clk); #1;
            n++;
        end while (!v && n < 20);
        if (!v) begin
            checks++; errors++;
            $display("FAIL drain_timeout: out_valid stayed 0 for %0d cycles", n);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DB; i++) gap_tbl[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bit_ready", 32'(bit_ready_e), 32'd1);
        chk("rst_out_valid", 32'(out_valid_e), 32'd0);
        chk("rst_data_out", 32'(data_out_e), 32'd0);
        chk("rst_err_count", 32'(err_count_e), 32'd0);
        @(posedge clk); #1;

        send_frame(8'hA5, 1'b0);
        @(negedge clk);
        chk("a5_latency_valid", 32'(out_valid_e), 32'd1);
        chk("a5_data", 32'(data_out_e), 32'hA5);
        chk("a5_perr_even", 32'(parity_err_e), 32'd0);
        chk("a5_errcnt_even", 32'(err_count_e), 32'd0);
        chk("a5_perr_odd", 32'(parity_err_o), 32'd1);
        @(posedge clk); #1;
        drain();

        send_frame(8'hA5, 1'b1);
        @(negedge clk);
        chk("a5bad_perr", 32'(parity_err_e), 32'd1);
        chk("a5bad_errcnt", 32'(err_count_e), 32'd1);
        @(posedge clk); #1;
        drain();

        send_frame(8'h07, 1'b0);
        @(negedge clk);
        chk("x07_perr_odd", 32'(parity_err_o), 32'd0);
        chk("x07_data_odd", 32'(data_out_o), 32'h07);
        @(posedge clk); #1;

        // frame 0x07 is held; offer bits for 5 cycles with no out_ready
        out_ready = 1'b0;
        bit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit_in = i[0];
            @(negedge clk);
            chk("bp_bit_ready", 32'(bit_ready_e), 32'd0);
            chk("bp_out_valid", 32'(out_valid_e), 32'd1);
            chk("bp_data", 32'(data_out_e), 32'h07);
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid_drop", 32'(out_valid_e), 32'd0);
        chk("bp_ready_back", 32'(bit_ready_e), 32'd1);
        @(posedge clk); #1;

        gap_tbl[2] = 1;
        gap_tbl[5] = 7;
        send_frame(8'h3C, 1'b0);
        gap_tbl[2] = 0;
        gap_tbl[5] = 0;
        @(negedge clk);
        chk("gap_data", 32'(data_out_e), 32'h3C);
        chk("gap_perr", 32'(parity_err_e), 32'd0);
        @(posedge clk); #1;
        drain();

        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", 32'(out_valid_e), 32'd0);
        chk("midrst_data", 32'(data_out_e), 32'd0);
        chk("midrst_perr", 32'(parity_err_e), 32'd0);
        chk("midrst_errcnt", 32'(err_count_e), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_pulse", 32'(out_valid_e), 32'd0);
        @(posedge clk); #1;
        send_frame(8'hFF, 1'b0);
        @(negedge clk);
        chk("ff_data", 32'(data_out_e), 32'hFF);
        chk("ff_perr", 32'(parity_err_e), 32'd0);
        @(posedge clk); #1;
        drain();

        for (int f = 0; f < 260; f++) begin
            send_frame(8'h01, 1'b0);
            drain();
        end
        @(negedge clk);
        chk("sat_errcnt", 32'(err_count_e), 32'd255);
        @(posedge clk); #1;
        send_frame(8'h01, 1'b0);
        @(negedge clk);
        chk("sat_hold_errcnt", 32'(err_count_e), 32'd255);
        chk("sat_hold_perr", 32'(parity_err_e), 32'd1);
        @(posedge clk); #1;
        drain();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
